// File: rtl/shreg_pkg.sv
// Shared types and frame-geometry helpers for the serial configuration chain loader.
package shreg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int DEF_CHAIN_LEN = 1600;
  localparam int DEF_WORD_W    = 32;

  function automatic int words_per_frame(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits taken from the final word of a frame; a full word when the chain divides evenly.
  function automatic int last_word_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/shreg_deserializer.sv
// Packs bits leaving the chain into LSB-first readback words, one rd_valid pulse per word.
module shreg_deserializer
  import shreg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              sample_bit,
  input  logic              frame_last,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = sample_bit;
  end

  // acc is cleared on every emitted word so a short final word comes out zero-padded.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      idx      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (sample_en) begin
        if (frame_last || (idx == IDX_LAST)) begin
          rd_data  <= acc_nxt;
          rd_valid <= 1'b1;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc <= acc_nxt;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/shreg_loader.sv
// Streams host config words LSB-first into a CHAIN_LEN-bit serial shift chain.
// Define SHREG_READBACK_EN to capture the bits leaving the chain as readback words.
module shreg_loader
  import shreg_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shreg_in,
  output logic              shreg_en,
  input  logic              shreg_out,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int WPF       = words_per_frame(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W    = $clog2(WPF + 1);
  localparam int BCNT_W    = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WPF_C       = WCNT_W'(WPF);
  localparam logic [WCNT_W-1:0] WPF_LAST_C  = WCNT_W'(WPF - 1);
  localparam logic [BCNT_W-1:0] WORD_BITS_C = BCNT_W'(WORD_W);
  localparam logic [BCNT_W-1:0] LAST_BITS_C = BCNT_W'(LAST_BITS);

  state_t            state;
  logic [WORD_W-1:0] word_sr;
  logic [BCNT_W-1:0] bits_left;
  logic [CNT_W-1:0]  bits_sent;
  logic [WCNT_W-1:0] words_taken;
  logic [BCNT_W-1:0] load_bits;
  logic              words_remain;
  logic              word_last_bit;
  logic              xfer;

  // bits_left counts bits of the current word still to follow the one now on shreg_in.
  assign words_remain  = (words_taken < WPF_C);
  assign word_last_bit = (bits_left == '0);
  assign load_bits     = (words_taken == WPF_LAST_C) ? LAST_BITS_C : WORD_BITS_C;
  assign xfer          = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == LOAD)
        in_ready = words_remain;
      else if (state == SHIFT)
        in_ready = word_last_bit && words_remain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      shreg_in    <= 1'b0;
      shreg_en    <= 1'b0;
      bits_left   <= '0;
      bits_sent   <= '0;
      words_taken <= '0;
    end else begin
      done     <= 1'b0;
      shreg_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            bits_left   <= '0;
            bits_sent   <= '0;
            words_taken <= '0;
          end
        end
        LOAD, SHIFT: begin
          if ((state == SHIFT) && !word_last_bit) begin
            shreg_in  <= word_sr[0];
            shreg_en  <= 1'b1;
            bits_left <= bits_left - BCNT_W'(1);
            bits_sent <= bits_sent + CNT_W'(1);
          end else if (xfer) begin
            shreg_in    <= in_data[0];
            shreg_en    <= 1'b1;
            bits_left   <= load_bits - BCNT_W'(1);
            bits_sent   <= bits_sent + CNT_W'(1);
            words_taken <= words_taken + WCNT_W'(1);
            state       <= SHIFT;
          end else if (bits_sent == CHAIN_LEN_C) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            // Word exhausted with nothing offered: hold shreg_in, chain stays put.
            state <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)
      word_sr <= in_data >> 1;
    else if ((state == SHIFT) && !word_last_bit)
      word_sr <= word_sr >> 1;
  end

`ifdef SHREG_READBACK_EN
  logic frame_last;

  assign frame_last = shreg_en && word_last_bit && (bits_sent == CHAIN_LEN_C);

  shreg_deserializer #(
    .WORD_W (WORD_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (shreg_en),
    .sample_bit (shreg_out),
    .frame_last (frame_last),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );
`else
  logic unused_shreg_out;

  assign unused_shreg_out = shreg_out;
  assign rd_data          = '0;
  assign rd_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_shreg_loader.sv
// Bench for shreg_loader: default 1600/32 instance plus a 10/4 instance, each with a chain model.
`timescale 1ns/1ps
module tb_shreg_loader;
  import shreg_pkg::*;

  localparam int CL  = 1600;
  localparam int WW  = 32;
  localparam int NW  = 50;
  localparam int SCL = 10;
  localparam int SWW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, in_valid;
  logic [WW-1:0] in_data;
  logic          busy, done, in_ready, shreg_in, shreg_en, shreg_out, rd_valid;
  logic [WW-1:0] rd_data;
  logic [CL-1:0] chain;

  logic           s_start, s_in_valid;
  logic [SWW-1:0] s_in_data;
  logic           s_busy, s_done, s_in_ready, s_shreg_in, s_shreg_en, s_shreg_out, s_rd_valid;
  logic [SWW-1:0] s_rd_data;
  logic [SCL-1:0] chain_s;

  shreg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .shreg_in(shreg_in), .shreg_en(shreg_en), .shreg_out(shreg_out),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  shreg_loader #(.CHAIN_LEN(SCL), .WORD_W(SWW)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .shreg_in(s_shreg_in), .shreg_en(s_shreg_en), .shreg_out(s_shreg_out),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid)
  );

  // Target chains: shift toward index 0 on enabled edges; index 0 is the chain output.
  always @(posedge clk) if (shreg_en) chain <= {shreg_in, chain[CL-1:1]};
  always @(posedge clk) if (s_shreg_en) chain_s <= {s_shreg_in, chain_s[SCL-1:1]};
  assign shreg_out   = chain[0];
  assign s_shreg_out = chain_s[0];

  int total = 0;
  int bad   = 0;

  int en_cnt, en_runs, max_gap, done_cnt, done_gap, sb_bad, ready_drop;
  bit timed_out;
  logic [WW-1:0] drv_q[$];
  logic [WW-1:0] sb_q[$];
  logic [WW-1:0] rd_q[$];

  // Drives one frame on the default instance; expected words go to sb_q on transfer
  // and are popped as each word's bits come out on shreg_in.
  task automatic run_frame(input bit do_start, input int stall_at, input int stall_len,
                           input int abort_bit, input bit tail);
    int cyc, last_en, stall_cnt, bitpos, words_sent, guard;
    bit prev_en, have_word;
    logic [WW-1:0] cur, exp_w;
    en_cnt = 0; en_runs = 0; max_gap = 0; done_cnt = 0; done_gap = -1;
    sb_bad = 0; ready_drop = 0; timed_out = 0;
    drv_q.delete(); sb_q.delete(); rd_q.delete();
    last_en = -100; stall_cnt = 0; bitpos = 0; words_sent = 0;
    prev_en = 0; have_word = 0; cur = '0;
    in_valid = 0;
    if (do_start) begin
      start = 1; guard = 0;
      do begin @(posedge clk); @(negedge clk); guard++; end while (!busy && guard < 10);
      start = 0;
      if (!busy) timed_out = 1;
    end
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (rd_valid) rd_q.push_back(rd_data);
      if (shreg_en) begin
        if (!prev_en) begin
          en_runs++;
          if (en_cnt > 0 && (cyc - last_en - 1) > max_gap) max_gap = cyc - last_en - 1;
        end
        cur[bitpos] = shreg_in;
        bitpos++; en_cnt++; last_en = cyc;
        if (bitpos == WW || en_cnt == CL) begin
          exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : ~cur;
          if (cur !== exp_w) sb_bad++;
          cur = '0; bitpos = 0;
        end
      end
      prev_en = shreg_en;
      if (done) begin done_cnt++; done_gap = cyc - last_en; end
      if (done || (abort_bit >= 0 && en_cnt >= abort_bit)) break;
      if (words_sent == stall_at && stall_cnt < stall_len) begin
        in_valid = 0;
        if (in_ready) stall_cnt++;
        else if (stall_cnt > 0) ready_drop++;
      end else if (words_sent < NW) begin
        if (!have_word) begin in_data = $urandom; have_word = 1; end
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      if (in_valid && in_ready) begin
        drv_q.push_back(in_data); sb_q.push_back(in_data);
        words_sent++; have_word = 0;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0;
    if (done_cnt == 0 && abort_bit < 0) timed_out = 1;
    if (tail) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); @(negedge clk);
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1; in_data = $urandom;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0; rst = 1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    total++; if (shreg_en !== 1'b0) begin bad++; $display("FAIL rst_shreg_en got=%0b want=0", shreg_en); end
    total++; if (shreg_in !== 1'b0) begin bad++; $display("FAIL rst_shreg_in got=%0b want=0", shreg_in); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0b want=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h want=0", rd_data); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state, IDLE); end
    rst = 0; start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_start_accept busy got=%0b want=1", busy); end
    run_frame(0, -1, 0, -1, 1);
    total++; if (en_cnt !== CL) begin bad++; $display("FAIL rst_after_en_cnt got=%0d want=%0d", en_cnt, CL); end
  endtask

  task automatic test_full_frame();
    logic [CL-1:0] exp_chain;
    run_frame(1, -1, 0, -1, 1);
    exp_chain = '0;
    for (int i = 0; i < drv_q.size() && i < NW; i++) exp_chain[i*WW +: WW] = drv_q[i];
    total++; if (timed_out) begin bad++; $display("FAIL full_timeout got=1 want=0"); end
    total++; if (en_cnt !== CL) begin bad++; $display("FAIL full_en_cnt got=%0d want=%0d", en_cnt, CL); end
    total++; if (en_runs !== 1) begin bad++; $display("FAIL full_contiguous runs got=%0d want=1", en_runs); end
    total++; if (sb_bad !== 0) begin bad++; $display("FAIL full_word_data bad_words got=%0d want=0", sb_bad); end
    total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL full_words_left got=%0d want=0", sb_q.size()); end
    total++; if (drv_q.size() !== NW) begin bad++; $display("FAIL full_words_taken got=%0d want=%0d", drv_q.size(), NW); end
    total++; if (done_gap !== 1) begin bad++; $display("FAIL full_done_gap got=%0d want=1", done_gap); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
    total++; if (chain !== exp_chain) begin
      bad++; $display("FAIL full_chain diff_bits got=%0d want=0", $countones(chain ^ exp_chain));
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] a_q[$];
    run_frame(1, -1, 0, -1, 0);
    a_q = drv_q;
    start = 1;
    @(posedge clk); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_start_on_done busy got=%0b want=0", busy); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL b2b_idle state got=%0d want=%0d", dut.state, IDLE); end
    @(posedge clk); @(negedge clk);
    start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_start_next busy got=%0b want=1", busy); end
    run_frame(0, -1, 0, -1, 1);
    total++; if (en_cnt !== CL) begin bad++; $display("FAIL b2b_en_cnt got=%0d want=%0d", en_cnt, CL); end
    total++; if (sb_bad !== 0) begin bad++; $display("FAIL b2b_word_data bad_words got=%0d want=0", sb_bad); end
`ifdef SHREG_READBACK_EN
    total++; if (rd_q.size() !== NW) begin bad++; $display("FAIL b2b_rd_pulses got=%0d want=%0d", rd_q.size(), NW); end
    for (int i = 0; i < NW && i < rd_q.size() && i < a_q.size(); i++) begin
      total++;
      if (rd_q[i] !== a_q[i]) begin bad++; $display("FAIL b2b_rd_word[%0d] got=%h want=%h", i, rd_q[i], a_q[i]); end
    end
`else
    total++; if (rd_q.size() !== 0) begin bad++; $display("FAIL b2b_rd_pulses got=%0d want=0", rd_q.size()); end
`endif
  endtask

  task automatic test_stall();
    run_frame(1, 20, 5, -1, 1);
    total++; if (en_cnt !== CL) begin bad++; $display("FAIL stall_en_cnt got=%0d want=%0d", en_cnt, CL); end
    total++; if (en_runs !== 2) begin bad++; $display("FAIL stall_runs got=%0d want=2", en_runs); end
    total++; if (max_gap < 5) begin bad++; $display("FAIL stall_gap got=%0d want>=5", max_gap); end
    total++; if (ready_drop !== 0) begin bad++; $display("FAIL stall_ready_held drops got=%0d want=0", ready_drop); end
    total++; if (sb_bad !== 0) begin bad++; $display("FAIL stall_word_data bad_words got=%0d want=0", sb_bad); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_short_chain();
    logic [11:0]    fw;
    logic [SCL-1:0] got, exp_bits;
    logic [SWW-1:0] rdw[$];
    int cyc, xfer_cyc, done_cyc, nen, widx;
    for (int f = 0; f < 2; f++) begin
      fw       = (f == 0) ? 12'hFAF : 12'h721;
      exp_bits = (f == 0) ? 10'h3AF : 10'h321;
      got = '0; nen = 0; widx = 0; xfer_cyc = -1; done_cyc = -1; rdw.delete();
      s_start = 1;
      @(posedge clk); @(negedge clk);
      s_start = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
        if (s_rd_valid) rdw.push_back(s_rd_data);
        if (s_shreg_en) begin
          if (nen < SCL) got[nen] = s_shreg_in;
          nen++;
        end
        if (s_done) begin done_cyc = cyc; break; end
        s_in_valid = (widx < 3);
        s_in_data  = (widx < 3) ? fw[widx*4 +: 4] : '0;
        if (s_in_valid && s_in_ready) begin
          if (xfer_cyc < 0) xfer_cyc = cyc;
          widx++;
        end
        @(posedge clk); @(negedge clk);
      end
      s_in_valid = 0;
      total++; if (nen !== SCL) begin bad++; $display("FAIL short%0d_en_cnt got=%0d want=%0d", f, nen, SCL); end
      total++; if (got !== exp_bits) begin bad++; $display("FAIL short%0d_bits got=%h want=%h", f, got, exp_bits); end
      total++; if (done_cyc < 0 || (done_cyc - xfer_cyc) !== 11) begin
        bad++; $display("FAIL short%0d_done_latency got=%0d want=11", f, done_cyc - xfer_cyc);
      end
      if (f == 1) begin
`ifdef SHREG_READBACK_EN
        total++; if (rdw.size() !== 3) begin bad++; $display("FAIL short_rd_pulses got=%0d want=3", rdw.size()); end
        if (rdw.size() == 3) begin
          total++; if (rdw[0] !== 4'hF) begin bad++; $display("FAIL short_rd0 got=%h want=f", rdw[0]); end
          total++; if (rdw[1] !== 4'hA) begin bad++; $display("FAIL short_rd1 got=%h want=a", rdw[1]); end
          total++; if (rdw[2] !== 4'h3) begin bad++; $display("FAIL short_rd2 got=%h want=3", rdw[2]); end
        end
`else
        total++; if (rdw.size() !== 0) begin bad++; $display("FAIL short_rd_pulses got=%0d want=0", rdw.size()); end
`endif
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_abort();
    run_frame(1, -1, 0, 700, 0);
    total++; if (en_cnt !== 700) begin bad++; $display("FAIL abort_reach got=%0d want=700", en_cnt); end
    rst = 1;
    @(posedge clk); @(negedge clk);
    total++; if (shreg_en !== 1'b0) begin bad++; $display("FAIL abort_shreg_en got=%0b want=0", shreg_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    rst = 0;
    run_frame(1, -1, 0, -1, 1);
    total++; if (en_cnt !== CL) begin bad++; $display("FAIL abort_new_en_cnt got=%0d want=%0d", en_cnt, CL); end
    total++; if (en_runs !== 1) begin bad++; $display("FAIL abort_new_runs got=%0d want=1", en_runs); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_count got=%0d want=1", done_cnt); end
    total++; if (sb_bad !== 0) begin bad++; $display("FAIL abort_word_data bad_words got=%0d want=0", sb_bad); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = '0;
    s_start = 0; s_in_valid = 0; s_in_data = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_stall();
    test_short_chain();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
